// File: rtl/fsm_pkg.sv
// Shared definitions for the parametrised FIFO-bank control FSM.
// State encoding and state width used by the controller and its bench.
package fsm_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   // Thresholds are consistent only when low sits strictly below high.
   function automatic logic thr_valid(
      input logic [31:0] alto,
      input logic [31:0] bajo
   );
      return (bajo < alto);
   endfunction

endpackage

// File: rtl/fsm_idle_counter.sv
// Saturating counter of consecutive all-empty cycles seen in ACTIVE.
// done flags the increment that reaches IDLE_HOLD; the count then wraps to 0.
module fsm_idle_counter #(
   parameter int IDLE_HOLD = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic done
);

   localparam int CW = $clog2(IDLE_HOLD + 1);
   localparam logic [CW-1:0] LAST = CW'(IDLE_HOLD - 1);
   localparam logic [CW-1:0] MAX  = CW'(IDLE_HOLD);

   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;

   // Next count: clear wins, the terminal increment restarts at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
         end else if (cnt_q != MAX) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Terminal-count indication for the controller's ACTIVE -> IDLE exit.
   always_comb begin
      done = inc && !clear && (cnt_q == LAST);
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fsm_ctrl_param.sv
// Main control FSM for the FIFO datapath: latches and checks thresholds,
// tracks bank occupancy with an idle hold-off and keeps a sticky error record.
module fsm_ctrl_param
   import fsm_pkg::*;
#(
   parameter int N_FIFO    = 10,
   parameter int UMBRAL_W  = 3,
   parameter int IDLE_HOLD = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic [UMBRAL_W-1:0] umbral_alto,
   input  logic [UMBRAL_W-1:0] umbral_bajo,
   input  logic [N_FIFO-1:0]   fifo_empty,
   input  logic [N_FIFO-1:0]   fifo_error,
   output logic [2:0]          state,
   output logic                idle,
   output logic                active,
   output logic                error,
   output logic [UMBRAL_W-1:0] interno_alto,
   output logic [UMBRAL_W-1:0] interno_bajo,
   output logic [N_FIFO-1:0]   error_vector
);

   state_t              state_d;
   state_t              state_q;
   logic                idle_q;
   logic                active_q;
   logic                error_q;
   logic [UMBRAL_W-1:0] alto_d;
   logic [UMBRAL_W-1:0] alto_q;
   logic [UMBRAL_W-1:0] bajo_d;
   logic [UMBRAL_W-1:0] bajo_q;
   logic [N_FIFO-1:0]   ev_d;
   logic [N_FIFO-1:0]   ev_q;

   logic any_err;
   logic all_empty;
   logic thr_ok;
   logic hold_inc;
   logic hold_clr;
   logic hold_done;

   // Input condensation shared by the transition logic and the counter.
   always_comb begin
      any_err   = |fifo_error;
      all_empty = &fifo_empty;
      thr_ok    = thr_valid(32'(umbral_alto), 32'(umbral_bajo));
   end

   // Count only all-empty cycles that would otherwise stay in ACTIVE.
   always_comb begin
      hold_inc = (state_q == ST_ACTIVE) && all_empty && !any_err && !init;
      hold_clr = !hold_inc;
   end

   fsm_idle_counter #(
      .IDLE_HOLD (IDLE_HOLD)
   ) u_idle_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (hold_clr),
      .inc   (hold_inc),
      .done  (hold_done)
   );

   // Next-state, threshold latch and sticky error record.
   always_comb begin
      state_d = state_q;
      alto_d  = alto_q;
      bajo_d  = bajo_q;
      ev_d    = ev_q;

      if (state_q == ST_INIT) begin
         alto_d = umbral_alto;
         bajo_d = umbral_bajo;
      end

      if (state_q == ST_RESET) begin
         state_d = ST_INIT;
      end else if (any_err) begin
         state_d = ST_ERROR;
         ev_d    = ev_q | fifo_error;
      end else if (init) begin
         state_d = ST_INIT;
         if (state_q == ST_ERROR) begin
            ev_d = '0;
         end
      end else begin
         unique case (state_q)
            ST_INIT: begin
               if (thr_ok) begin
                  state_d = ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (!all_empty) begin
                  state_d = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (hold_done) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // State and registered output decode, all on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RESET;
         idle_q   <= 1'b0;
         active_q <= 1'b0;
         error_q  <= 1'b0;
         alto_q   <= '0;
         bajo_q   <= '0;
         ev_q     <= '0;
      end else begin
         state_q  <= state_d;
         idle_q   <= (state_d == ST_IDLE);
         active_q <= (state_d == ST_ACTIVE);
         error_q  <= (state_d == ST_ERROR);
         alto_q   <= alto_d;
         bajo_q   <= bajo_d;
         ev_q     <= ev_d;
      end
   end

   assign state        = state_q;
   assign idle         = idle_q;
   assign active       = active_q;
   assign error        = error_q;
   assign interno_alto = alto_q;
   assign interno_bajo = bajo_q;
   assign error_vector = ev_q;

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Directed self-checking bench for fsm_ctrl_param.
// Hand-computed expectations, checked with immediate assertions.
module tb_fsm_ctrl_param;

   localparam int N_FIFO   = 10;
   localparam int UMBRAL_W = 3;

   logic                clk;
   logic                reset;
   logic                init;
   logic [UMBRAL_W-1:0] umbral_alto;
   logic [UMBRAL_W-1:0] umbral_bajo;
   logic [N_FIFO-1:0]   fifo_empty;
   logic [N_FIFO-1:0]   fifo_error;
   logic [2:0]          state;
   logic                idle;
   logic                active;
   logic                error;
   logic [UMBRAL_W-1:0] interno_alto;
   logic [UMBRAL_W-1:0] interno_bajo;
   logic [N_FIFO-1:0]   error_vector;

   int checks;
   int failures;

   fsm_ctrl_param #(
      .N_FIFO    (N_FIFO),
      .UMBRAL_W  (UMBRAL_W),
      .IDLE_HOLD (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .umbral_alto  (umbral_alto),
      .umbral_bajo  (umbral_bajo),
      .fifo_empty   (fifo_empty),
      .fifo_error   (fifo_error),
      .state        (state),
      .idle         (idle),
      .active       (active),
      .error        (error),
      .interno_alto (interno_alto),
      .interno_bajo (interno_bajo),
      .error_vector (error_vector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output snapshot: state, decode flags, thresholds, error record.
   task automatic chk_all(input string tag, input int st, input int ia,
                          input int ib, input int ev);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".idle"}, 32'(idle), 32'(st == 2));
      chk({tag, ".active"}, 32'(active), 32'(st == 3));
      chk({tag, ".error"}, 32'(error), 32'(st == 4));
      chk({tag, ".ialto"}, 32'(interno_alto), 32'(ia));
      chk({tag, ".ibajo"}, 32'(interno_bajo), 32'(ib));
      chk({tag, ".evec"}, 32'(error_vector), 32'(ev));
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      init        = 1'b0;
      umbral_alto = 3'd6;
      umbral_bajo = 3'd3;
      fifo_empty  = '1;
      fifo_error  = '0;

      // Power-up
      step;
      step;
      chk_all("rst", 0, 0, 0, 0);
      reset = 1'b0;
      step;
      chk_all("pu_e1", 1, 0, 0, 0);
      step;
      chk_all("pu_e2", 2, 6, 3, 0);

      // Invalid thresholds hold INIT
      umbral_alto = 3'd2;
      umbral_bajo = 3'd5;
      init = 1'b1;
      step;
      chk_all("reinit", 1, 6, 3, 0);
      init = 1'b0;
      step;
      chk_all("inval", 1, 2, 5, 0);
      umbral_alto = 3'd7;
      umbral_bajo = 3'd2;
      step;
      chk_all("valid", 2, 7, 2, 0);

      // Equal thresholds are invalid too
      umbral_alto = 3'd4;
      umbral_bajo = 3'd4;
      init = 1'b1;
      step;
      init = 1'b0;
      step;
      chk_all("eq_thr", 1, 4, 4, 0);
      umbral_alto = 3'd7;
      umbral_bajo = 3'd2;
      step;
      chk_all("eq_fix", 2, 7, 2, 0);

      // Activity and hold-off
      fifo_empty = 10'h001;
      step;
      chk_all("act", 3, 7, 2, 0);
      fifo_empty = '1;
      step;
      chk_all("hold1", 3, 7, 2, 0);
      fifo_empty = 10'h3fe;
      step;
      chk_all("busy", 3, 7, 2, 0);
      fifo_empty = '1;
      step;
      chk_all("hold1b", 3, 7, 2, 0);
      step;
      chk_all("hold2", 2, 7, 2, 0);

      // Sticky error record
      fifo_empty = 10'h001;
      step;
      chk_all("act2", 3, 7, 2, 0);
      fifo_error = 10'h004;
      step;
      chk_all("err1", 4, 7, 2, 10'h004);
      fifo_error = 10'h100;
      step;
      chk_all("err2", 4, 7, 2, 10'h104);
      fifo_error = '0;
      step;
      chk_all("errhold", 4, 7, 2, 10'h104);
      init = 1'b1;
      step;
      chk_all("errclr", 1, 7, 2, 0);
      init = 1'b0;
      fifo_empty = '1;
      step;
      chk_all("back", 2, 7, 2, 0);

      // Error beats init on the same edge
      fifo_error = 10'h001;
      init = 1'b1;
      step;
      chk_all("prio", 4, 7, 2, 10'h001);
      step;
      chk_all("prio2", 4, 7, 2, 10'h001);
      fifo_error = '0;
      step;
      chk_all("prio_ex", 1, 7, 2, 0);
      init = 1'b0;
      step;
      chk_all("prio_id", 2, 7, 2, 0);

      // Asynchronous reset in ACTIVE
      fifo_empty = 10'h001;
      step;
      chk_all("act3", 3, 7, 2, 0);
      #2;
      reset = 1'b1;
      #1;
      chk_all("arst", 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      step;
      chk_all("arst_e1", 1, 0, 0, 0);
      step;
      chk_all("arst_e2", 2, 7, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
